// File: rtl/strassen_stream_mult.sv
// strassen_stream_mult
//   Streams in two signed NxN matrices A and B (A row-major, then B row-major),
//   forms the seven Strassen quadrant products M1..M7 with one sequential MAC,
//   then streams C = A*B out row-major under valid/ready backpressure.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   start      one-cycle job request, honoured only in IDLE
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last C element is accepted
//   in_valid   operand beat valid
//   in_ready   high only in LOAD
//   in_data    operand element (DATA_W, signed)
//   out_valid  C element valid
//   out_ready  downstream accepts C element
//   out_data   C element (OUT_W, signed, two's-complement wrap)
//
// Latency: counting the cycle in which start is high as cycle 0, with
// in_valid and out_ready held high, out_valid first rises in cycle
// 1 + 2*N*N + 7*H*H*H (H = N/2).
module strassen_stream_mult #(
  parameter int N      = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  localparam int H  = N / 2;
  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam int LW = AW + 1;
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam int MD = 7 * H * H;
  localparam int MW = $clog2(MD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COMP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [HW-1:0] HLAST = HW'(H - 1);
  localparam logic [AW-1:0] DLAST = AW'(NN - 1);
  localparam logic [LW-1:0] LLAST = LW'(2 * NN - 1);

  logic [1:0]    state;
  logic [LW-1:0] ld_idx;
  logic [2:0]    mx;
  logic [HW-1:0] r, c, k;
  logic [AW-1:0] d_idx;

  logic signed [DATA_W-1:0] amem [NN];
  logic signed [DATA_W-1:0] bmem [NN];
  logic signed [ACC_W-1:0]  mmem [MD];
  logic signed [ACC_W-1:0]  acc;

  function automatic logic [AW-1:0] aadr(input int row, input int col);
    return AW'(row * N + col);
  endfunction

  function automatic logic [MW-1:0] madr(input int m, input int row, input int col);
    return MW'(m * H * H + row * H + col);
  endfunction

  function automatic logic signed [DATA_W:0] sx1(input logic signed [DATA_W-1:0] x);
    return {x[DATA_W-1], x};
  endfunction

  function automatic logic signed [ACC_W+1:0] sx2(input logic signed [ACC_W-1:0] x);
    return {{2{x[ACC_W-1]}}, x};
  endfunction

  // Keep the low OUT_W bits: two's-complement wrap, no saturation.
  function automatic logic [OUT_W-1:0] wrap_out(input logic signed [ACC_W+1:0] x);
    return OUT_W'(x);
  endfunction

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_LOAD);

  // MAC operand formation: A terms indexed (r,k), B terms indexed (k,c).
  logic signed [DATA_W-1:0]   a11, a12, a21, a22, b11, b12, b21, b22;
  logic signed [DATA_W:0]     ta, tb;
  logic signed [2*DATA_W+1:0] prod;
  logic signed [ACC_W-1:0]    base, prod_x, acc_next;

  always_comb begin
    a11 = amem[aadr(int'(r),     int'(k))];
    a12 = amem[aadr(int'(r),     int'(k) + H)];
    a21 = amem[aadr(int'(r) + H, int'(k))];
    a22 = amem[aadr(int'(r) + H, int'(k) + H)];
    b11 = bmem[aadr(int'(k),     int'(c))];
    b12 = bmem[aadr(int'(k),     int'(c) + H)];
    b21 = bmem[aadr(int'(k) + H, int'(c))];
    b22 = bmem[aadr(int'(k) + H, int'(c) + H)];
    ta  = sx1(a12) - sx1(a22);
    tb  = sx1(b21) + sx1(b22);
    case (mx)
      3'd0: begin ta = sx1(a11) + sx1(a22); tb = sx1(b11) + sx1(b22); end
      3'd1: begin ta = sx1(a21) + sx1(a22); tb = sx1(b11);             end
      3'd2: begin ta = sx1(a11);             tb = sx1(b12) - sx1(b22); end
      3'd3: begin ta = sx1(a22);             tb = sx1(b21) - sx1(b11); end
      3'd4: begin ta = sx1(a11) + sx1(a12); tb = sx1(b22);             end
      3'd5: begin ta = sx1(a21) - sx1(a11); tb = sx1(b11) + sx1(b12); end
      default: begin end
    endcase
    prod     = ta * tb;
    prod_x   = ACC_W'(prod);
    base     = (k == '0) ? '0 : acc;
    acc_next = base + prod_x;
  end

  // Output combination for element (di,dj) from the stored M products.
  int di, dj, li, lj;
  logic signed [ACC_W-1:0] m1, m2, m3, m4, m5, m6, m7;
  logic signed [ACC_W+1:0] comb;

  always_comb begin
    di = int'(d_idx) / N;
    dj = int'(d_idx) % N;
    li = di % H;
    lj = dj % H;
    m1 = mmem[madr(0, li, lj)];
    m2 = mmem[madr(1, li, lj)];
    m3 = mmem[madr(2, li, lj)];
    m4 = mmem[madr(3, li, lj)];
    m5 = mmem[madr(4, li, lj)];
    m6 = mmem[madr(5, li, lj)];
    m7 = mmem[madr(6, li, lj)];
    case ({di >= H, dj >= H})
      2'b00:   comb = sx2(m1) + sx2(m4) - sx2(m5) + sx2(m7);
      2'b01:   comb = sx2(m3) + sx2(m5);
      2'b10:   comb = sx2(m2) + sx2(m4);
      default: comb = sx2(m1) - sx2(m2) + sx2(m3) + sx2(m6);
    endcase
    // d_idx only moves on acceptance, so out_data holds under stall.
    out_data = out_valid ? wrap_out(comb) : '0;
  end

  // Control: FSM and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ld_idx    <= '0;
      mx        <= '0;
      r         <= '0;
      c         <= '0;
      k         <= '0;
      d_idx     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) state <= S_LOAD;
        S_LOAD: begin
          if (in_valid) begin
            if (ld_idx == LLAST) begin
              ld_idx <= '0;
              state  <= S_COMP;
            end else begin
              ld_idx <= ld_idx + 1'b1;
            end
          end
        end
        S_COMP: begin
          if (k == HLAST) begin
            k <= '0;
            if (c == HLAST) begin
              c <= '0;
              if (r == HLAST) begin
                r <= '0;
                if (mx == 3'd6) begin
                  mx        <= '0;
                  state     <= S_DRAIN;
                  out_valid <= 1'b1;
                end else begin
                  mx <= mx + 1'b1;
                end
              end else begin
                r <= r + 1'b1;
              end
            end else begin
              c <= c + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            if (d_idx == DLAST) begin
              d_idx     <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_IDLE;
            end else begin
              d_idx <= d_idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Datapath storage: operands, accumulator and M products (not reset).
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      if (ld_idx[LW-1]) bmem[ld_idx[AW-1:0]] <= $signed(in_data);
      else              amem[ld_idx[AW-1:0]] <= $signed(in_data);
    end
    if (state == S_COMP) begin
      acc <= acc_next;
      if (k == HLAST) mmem[madr(int'(mx), int'(r), int'(c))] <= acc_next;
    end
  end

endmodule

// File: tb/tb_strassen_stream_mult.sv
// Testbench for strassen_stream_mult: an N=4 instance driven from a table of
// known matrix pairs and corner sequences, and a default N=16 instance driven
// with random operands and random handshakes, checked against a plain
// matrix-multiply reference.
module tb_strassen_stream_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, out_ready, sel16;
  logic [7:0] in_data;
  logic start4, start16;
  logic busy4, done4, ir4, ov4, busy16, done16, ir16, ov16;
  logic [15:0] od4, od16;
  logic busy, done, in_ready, out_valid;
  logic [15:0] out_data;

  assign start4    = start & ~sel16;
  assign start16   = start & sel16;
  assign busy      = sel16 ? busy16 : busy4;
  assign done      = sel16 ? done16 : done4;
  assign in_ready  = sel16 ? ir16   : ir4;
  assign out_valid = sel16 ? ov16   : ov4;
  assign out_data  = sel16 ? od16   : od4;

  strassen_stream_mult #(.N(4), .DATA_W(8), .ACC_W(24), .OUT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
  );

  strassen_stream_mult u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .busy(busy16), .done(done16),
    .in_valid(in_valid), .in_ready(ir16), .in_data(in_data),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16)
  );

  typedef struct packed {
    logic [127:0] a;
    logic [127:0] b;
    logic [255:0] c;
  } vec_t;

  vec_t vt [4];
  int a_m [256];
  int b_m [256];
  logic signed [15:0] exp_c [256];
  logic signed [15:0] got_c [256];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Reference: C = A*B by definition, wrapped to 16 bits.
  task automatic ref_model(input int nn);
    int s;
    logic signed [15:0] w;
    for (int i = 0; i < nn; i++)
      for (int j = 0; j < nn; j++) begin
        s = 0;
        for (int q = 0; q < nn; q++) s += a_m[i*nn+q] * b_m[q*nn+j];
        w = 16'(s);
        exp_c[i*nn+j] = w;
      end
  endtask

  task automatic rand_mats(input int nn);
    for (int e = 0; e < nn*nn; e++) begin
      a_m[e] = int'($urandom_range(0, 255)) - 128;
      b_m[e] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic load_vec(input int v);
    for (int e = 0; e < 16; e++) begin
      a_m[e]   = int'($signed(vt[v].a[8*e +: 8]));
      b_m[e]   = int'($signed(vt[v].b[8*e +: 8]));
      exp_c[e] = $signed(vt[v].c[16*e +: 16]);
    end
  endtask

  task automatic reset_check(input string nm);
    int dseen;
    rst = 1'b1;
    #1;
    chk({nm, " rst busy"},      int'(busy), 0);
    chk({nm, " rst done"},      int'(done), 0);
    chk({nm, " rst in_ready"},  int'(in_ready), 0);
    chk({nm, " rst out_valid"}, int'(out_valid), 0);
    chk({nm, " rst out_data"},  int'(out_data), 0);
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dseen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk({nm, " no done after rst"}, dseen, 0);
  endtask

  // abort_mode: 0 none, 1 reset mid-COMPUTE, 2 reset mid-DRAIN after 5 outputs
  task automatic run_job(input int nn, input bit rnd, input bit xstart,
                         input int abort_mode, input string nm);
    int beat, nout, cyc, dcnt, first_ov, comp_cyc;
    bit prev_stall;
    logic [15:0] prev_data;
    sel16 = (nn == 16);
    @(negedge clk);
    chk({nm, " idle in_ready"}, int'(in_ready), 0);
    chk({nm, " idle busy"},     int'(busy), 0);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    beat = 0; nout = 0; cyc = 0; dcnt = 0; first_ov = -1; comp_cyc = 0;
    prev_stall = 1'b0; prev_data = '0;
    while (nout < nn*nn) begin
      @(negedge clk);
      cyc++;
      if (cyc > 30000) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout: got %0d outputs, required %0d", nm, nout, nn*nn);
        break;
      end
      start = xstart && ((beat == 5 && in_ready) || (nout == 3 && out_valid));
      if (done) dcnt++;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (prev_stall) begin
        chk({nm, " stall valid"}, int'(out_valid), 1);
        chk({nm, " stall data"},  int'(out_data), int'(prev_data));
      end
      if (abort_mode == 1 && beat == 2*nn*nn) begin
        comp_cyc++;
        if (comp_cyc == 20) begin reset_check(nm); return; end
      end
      if (abort_mode == 2 && nout == 5) begin reset_check(nm); return; end
      in_valid = (beat < 2*nn*nn) && (!rnd || $urandom_range(0, 1) == 1);
      if (beat < nn*nn)        in_data = 8'(a_m[beat]);
      else if (beat < 2*nn*nn) in_data = 8'(b_m[beat - nn*nn]);
      else                     in_data = 8'd0;
      out_ready = !rnd || $urandom_range(0, 1) == 1;
      if (in_valid && in_ready) beat++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        got_c[nout] = $signed(out_data);
        nout++;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk({nm, " done pulses"}, dcnt, 1);
    chk({nm, " end busy"},      int'(busy), 0);
    chk({nm, " end out_valid"}, int'(out_valid), 0);
    if (nn == 4 && !rnd && !xstart)
      chk({nm, " latency"}, first_ov, 1 + 2*16 + 7*8);
    for (int e = 0; e < nn*nn; e++)
      chk($sformatf("%s c[%0d]", nm, e), int'(got_c[e]), int'(exp_c[e]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; sel16 = 1'b0;
    for (int e = 0; e < 16; e++) begin
      vt[0].a[8*e +: 8]   = ((e / 4) == (e % 4)) ? 8'd1 : 8'd0;
      vt[0].b[8*e +: 8]   = 8'(e + 1);
      vt[0].c[16*e +: 16] = 16'(e + 1);
      vt[1].a[8*e +: 8]   = 8'd2;
      vt[1].b[8*e +: 8]   = 8'd3;
      vt[1].c[16*e +: 16] = 16'd24;
      vt[2].a[8*e +: 8]   = 8'h80;
      vt[2].b[8*e +: 8]   = 8'h80;
      vt[2].c[16*e +: 16] = 16'd0;
      vt[3].a[8*e +: 8]   = 8'hFF;
      vt[3].b[8*e +: 8]   = 8'd1;
      vt[3].c[16*e +: 16] = 16'hFFFC;
    end

    repeat (2) @(negedge clk);
    chk("reset busy4",  int'(busy4), 0);
    chk("reset done4",  int'(done4), 0);
    chk("reset ready4", int'(ir4), 0);
    chk("reset ovld4",  int'(ov4), 0);
    chk("reset odat4",  int'(od4), 0);
    chk("reset busy16", int'(busy16), 0);
    chk("reset ovld16", int'(ov16), 0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      run_job(4, 1'b0, 1'b0, 0, $sformatf("vec%0d", v));
    end

    rand_mats(4);
    ref_model(4);
    run_job(4, 1'b1, 1'b0, 0, "rand4");

    load_vec(1);
    run_job(4, 1'b0, 1'b1, 0, "start_ignored");

    load_vec(1);
    run_job(4, 1'b0, 1'b0, 1, "rst_compute");
    run_job(4, 1'b1, 1'b0, 2, "rst_drain");
    load_vec(1);
    run_job(4, 1'b0, 1'b0, 0, "after_rst");

    rand_mats(16);
    ref_model(16);
    run_job(16, 1'b1, 1'b0, 0, "rand16");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
